// File: rtl/clock_manager_pkg.sv
// Shared types and constants for the clock divider bank.
//   ch_state_t        per-channel run state (CH_STEP is only reachable with CLKDIV_STEP_EN)
//   SLOW_RESET_LEVEL  level of every Slow_Clock while in reset
//   DEFAULT_DIV_C     divisor loaded at reset (half-period = DEFAULT_DIV_C + 1 cycles)
//   ch_width()        channel-select width, max(1, $clog2(n))
package clock_manager_pkg;

    typedef enum logic [1:0] {
        CH_RUN,
        CH_HALT,
        CH_STEP
    } ch_state_t;

    localparam logic        SLOW_RESET_LEVEL = 1'b1;
    localparam int unsigned DEFAULT_DIV_C    = 5;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One programmable divider channel: half-period counter, active/pending divisor,
// RUN/HALT (+STEP) state machine and registered outputs.
// Optional feature: CLKDIV_STEP_EN enables single-period stepping from HALT.
// Ports:
//   fast_clock  in   clock for every flop
//   reset       in   synchronous, active-high
//   run         in   run request (level)
//   step        in   single-period request pulse (unused without CLKDIV_STEP_EN)
//   cfg_wr      in   accepted divisor write for this channel (only while pending is low)
//   cfg_div     in   divisor value to latch on cfg_wr
//   pending     out  a written divisor is waiting to be applied
//   slow_clock  out  divided clock, registered
//   rise_tick   out  one-cycle pulse in the cycle slow_clock is newly high
//   halted      out  channel frozen in the high phase
module clock_divider_channel
    import clock_manager_pkg::*;
#(
    parameter int unsigned DIV_W        = 8,
    parameter int unsigned DEFAULT_DIV  = DEFAULT_DIV_C,
    parameter bit          RUN_ON_RESET = 1'b1
) (
    input  logic             fast_clock,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             cfg_wr,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             pending,
    output logic             slow_clock,
    output logic             rise_tick,
    output logic             halted
);

    ch_state_t        state_q, state_d;
    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             slow_q, slow_d;
    logic             rise_q, rise_d;
    // High only in the first cycle after reset: that cycle is treated as a rise
    // boundary so a channel with run low halts immediately.
    logic             fresh_q;
    logic             step_req;
    logic             at_end;

`ifdef CLKDIV_STEP_EN
    assign step_req = step;
`else
    logic unused_step;
    assign unused_step = step;
    assign step_req    = 1'b0;
`endif

    assign at_end = (count_q >= div_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        pdiv_d  = pdiv_q;
        pend_d  = pend_q;
        slow_d  = slow_q;
        rise_d  = 1'b0;

        case (state_q)
            CH_HALT: begin
                // Output is frozen high with count at 0; a waiting divisor lands now.
                if (pend_q) begin
                    div_d  = pdiv_q;
                    pend_d = 1'b0;
                end
                if (run) begin
                    state_d = CH_RUN;
                end else if (step_req) begin
                    state_d = CH_STEP;
                end
            end
            default: begin
                if (state_q == CH_RUN && fresh_q && !run) begin
                    state_d = CH_HALT;
                end else if (at_end) begin
                    count_d = '0;
                    slow_d  = ~slow_q;
                    rise_d  = ~slow_q;
                    // Divisor changes only at a toggle so no half-period is cut short.
                    if (pend_q) begin
                        div_d  = pdiv_q;
                        pend_d = 1'b0;
                    end
                    if (state_q == CH_STEP && run) begin
                        state_d = CH_RUN;
                    end
                    // Halting only on a rising toggle keeps the output high and runt-free.
                    if (!slow_q && !run) begin
                        state_d = CH_HALT;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                    if (state_q == CH_STEP && run) begin
                        state_d = CH_RUN;
                    end
                end
            end
        endcase

        if (cfg_wr) begin
            pdiv_d = cfg_div;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge fast_clock) begin
        if (reset) begin
            state_q <= RUN_ON_RESET ? CH_RUN : CH_HALT;
            count_q <= '0;
            div_q   <= DIV_W'(DEFAULT_DIV);
            pdiv_q  <= '0;
            pend_q  <= 1'b0;
            slow_q  <= SLOW_RESET_LEVEL;
            rise_q  <= 1'b0;
            fresh_q <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            pdiv_q  <= pdiv_d;
            pend_q  <= pend_d;
            slow_q  <= slow_d;
            rise_q  <= rise_d;
            fresh_q <= 1'b0;
        end
    end

    assign pending    = pend_q;
    assign slow_clock = slow_q;
    assign rise_tick  = rise_q;
    assign halted     = (state_q == CH_HALT);

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of N_CH independent programmable clock dividers on Fast_Clock.
// Optional feature: CLKDIV_STEP_EN enables per-channel single-period stepping.
// Ports:
//   Fast_Clock  in   clock for every flop
//   Reset       in   synchronous, active-high
//   Run         in   per-channel run request (level)
//   Step        in   per-channel single-period pulse (ignored without CLKDIV_STEP_EN)
//   cfg_valid   in   divisor write request
//   cfg_ready   out  write can be accepted (always 1 for cfg_ch >= N_CH)
//   cfg_ch      in   target channel
//   cfg_div     in   new divisor
//   Slow_Clock  out  divided clocks
//   Rise_Tick   out  one-cycle pulse when Slow_Clock is newly high
//   Halted      out  channel frozen in the high phase
module clock_divider_bank
    import clock_manager_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned DIV_W        = 8,
    parameter int unsigned DEFAULT_DIV  = DEFAULT_DIV_C,
    parameter bit          RUN_ON_RESET = 1'b1,
    localparam int unsigned CH_W        = ch_width(N_CH)
) (
    input  logic             Fast_Clock,
    input  logic             Reset,
    input  logic [N_CH-1:0]  Run,
    input  logic [N_CH-1:0]  Step,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [N_CH-1:0]  Slow_Clock,
    output logic [N_CH-1:0]  Rise_Tick,
    output logic [N_CH-1:0]  Halted
);

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] wr;

    // Out-of-range channels match no iteration: they read ready and writes vanish.
    always_comb begin
        cfg_ready = 1'b1;
        wr        = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (32'(cfg_ch) == i) begin
                cfg_ready = ~pending[i];
                wr[i]     = cfg_valid & ~pending[i];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clock_divider_channel #(
            .DIV_W        (DIV_W),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .RUN_ON_RESET (RUN_ON_RESET)
        ) u_ch (
            .fast_clock (Fast_Clock),
            .reset      (Reset),
            .run        (Run[g]),
            .step       (Step[g]),
            .cfg_wr     (wr[g]),
            .cfg_div    (cfg_div),
            .pending    (pending[g]),
            .slow_clock (Slow_Clock[g]),
            .rise_tick  (Rise_Tick[g]),
            .halted     (Halted[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank with a time-scheduled reference model.
module tb_clock_divider_bank;

    localparam int NC = 4;
    localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;
`ifdef CLKDIV_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic       Fast_Clock = 1'b0;
    logic       Reset;
    logic [3:0] Run, Step;
    logic       cfg_valid, cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [3:0] Slow_Clock, Rise_Tick, Halted;

    // Second bank with 3 channels so an out-of-range cfg_ch (3) is expressible.
    logic       b_valid, b_ready;
    logic [1:0] b_ch;
    logic [7:0] b_div;
    logic [2:0] b_slow, b_rise, b_halted;
    logic [2:0] b_run  = 3'b111;
    logic [2:0] b_step = 3'b000;

    int n_tests = 0;
    int n_fail  = 0;
    int ec      = 0;  // edges since the last reset edge

    always #5 Fast_Clock = ~Fast_Clock;

    clock_divider_bank #(.N_CH(4)) dut (
        .Fast_Clock (Fast_Clock), .Reset (Reset), .Run (Run), .Step (Step),
        .cfg_valid (cfg_valid), .cfg_ready (cfg_ready), .cfg_ch (cfg_ch), .cfg_div (cfg_div),
        .Slow_Clock (Slow_Clock), .Rise_Tick (Rise_Tick), .Halted (Halted)
    );

    clock_divider_bank #(.N_CH(3)) dut_b (
        .Fast_Clock (Fast_Clock), .Reset (Reset), .Run (b_run), .Step (b_step),
        .cfg_valid (b_valid), .cfg_ready (b_ready), .cfg_ch (b_ch), .cfg_div (b_div),
        .Slow_Clock (b_slow), .Rise_Tick (b_rise), .Halted (b_halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at edge %0d: got %0h, want %0h", name, ec, act, exp);
        end
    endtask

    task automatic goto(input int e);
        while (ec < e) @(negedge Fast_Clock);
    endtask

    // Reference model: each channel keeps the absolute edge of its next toggle.
    logic m_level[NC];
    logic m_rise[NC];
    int   m_mode[NC];
    int   m_div[NC];
    bit   m_pend[NC];
    int   m_pdiv[NC];
    int   m_next[NC];
    bit   m_fresh;

    always @(posedge Fast_Clock) begin
        bit acc[NC];
        for (int i = 0; i < NC; i++)
            acc[i] = cfg_valid && !m_pend[i] && (int'(cfg_ch) == i);
        if (Reset) begin
            ec = 0;
            m_fresh = 1'b1;
            for (int i = 0; i < NC; i++) begin
                m_level[i] = 1'b1; m_rise[i] = 1'b0; m_mode[i] = M_RUN;
                m_div[i] = 5; m_pend[i] = 1'b0; m_pdiv[i] = 0; m_next[i] = 6;
            end
        end else begin
            ec++;
            for (int i = 0; i < NC; i++) begin
                m_rise[i] = 1'b0;
                if (m_mode[i] == M_HALT) begin
                    if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 1'b0; end
                    if (Run[i]) begin
                        m_mode[i] = M_RUN; m_next[i] = ec + m_div[i] + 1;
                    end else if (STEP_EN && Step[i]) begin
                        m_mode[i] = M_STEP; m_next[i] = ec + m_div[i] + 1;
                    end
                end else if (m_mode[i] == M_RUN && m_fresh && !Run[i]) begin
                    m_mode[i] = M_HALT;
                end else begin
                    if (ec == m_next[i]) begin
                        m_level[i] = !m_level[i];
                        if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 1'b0; end
                        m_next[i] = ec + m_div[i] + 1;
                        if (m_level[i]) begin
                            m_rise[i] = 1'b1;
                            if (!Run[i]) m_mode[i] = M_HALT;
                        end
                    end
                    if (m_mode[i] == M_STEP && Run[i]) m_mode[i] = M_RUN;
                end
                if (acc[i]) begin m_pend[i] = 1'b1; m_pdiv[i] = int'(cfg_div); end
            end
            m_fresh = 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model and the fixed-rate second bank.
    always @(posedge Fast_Clock) begin
        logic [3:0] es, er, eh;
        logic [2:0] bs, br;
        #1;
        for (int i = 0; i < NC; i++) begin
            es[i] = m_level[i];
            er[i] = m_rise[i];
            eh[i] = (m_mode[i] == M_HALT);
        end
        chk("slow_clock", Slow_Clock, es);
        chk("rise_tick", Rise_Tick, er);
        chk("halted", Halted, eh);
        chk("cfg_ready", cfg_ready, !m_pend[cfg_ch]);
        bs = ((ec / 6) % 2 == 0) ? 3'b111 : 3'b000;
        br = (ec > 0 && ec % 12 == 0) ? 3'b111 : 3'b000;
        chk("b_slow_clock", b_slow, bs);
        chk("b_rise_tick", b_rise, br);
        chk("b_halted", b_halted, 3'b000);
        chk("b_cfg_ready", b_ready, 1'b1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, want done");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Run = 4'hF; Step = 4'h0;
        cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
        b_valid = 1'b0; b_ch = 2'd0; b_div = 8'd0;
        repeat (2) @(negedge Fast_Clock);
        chk("reset_slow", Slow_Clock, 4'hF);
        chk("reset_rise", Rise_Tick, 4'h0);
        chk("reset_halted", Halted, 4'h0);
        Reset = 1'b0;

        // Default divisor: fall on edge 6, rise on edge 12, one-cycle tick.
        goto(5);  chk("t1_high_e5", Slow_Clock, 4'hF);
        goto(6);  chk("t1_fall_e6", Slow_Clock, 4'h0);
        goto(11); chk("t1_low_e11", Slow_Clock, 4'h0);
        goto(12); chk("t1_rise_e12", Slow_Clock, 4'hF); chk("t1_tick_e12", Rise_Tick, 4'hF);
        goto(13); chk("t1_tick_e13", Rise_Tick, 4'h0);

        // Divisor write to ch2 two cycles after the fall at edge 18.
        goto(20);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd1;
        #1 chk("t2_ready_pre", cfg_ready, 1'b1);
        goto(21); cfg_valid = 1'b0;
        #1 chk("t2_ready_wait", cfg_ready, 1'b0);
        goto(23); chk("t2_ready_e23", cfg_ready, 1'b0);
        goto(24); chk("t2_ready_e24", cfg_ready, 1'b1); chk("t2_slow_e24", Slow_Clock, 4'hF);
        goto(26); chk("t2_slow_e26", Slow_Clock, 4'b1011);
        goto(28); chk("t2_slow_e28", Slow_Clock, 4'hF); chk("t2_tick_e28", Rise_Tick, 4'b0100);
        goto(30); chk("t2_slow_e30", Slow_Clock, 4'h0);

        // ch1 run dropped mid low phase: finishes low half, halts high.
        goto(32); Run[1] = 1'b0;
        goto(35); chk("t3_low_e35", Slow_Clock[1], 1'b0);
        goto(36); chk("t3_rise_e36", Slow_Clock[1], 1'b1); chk("t3_halt_e36", Halted[1], 1'b1);
        goto(42); chk("t3_held_e42", Slow_Clock[1], 1'b1); chk("t3_halt_e42", Halted[1], 1'b1);
        Run[1] = 1'b1;
        goto(43); chk("t3_resume_e43", Halted[1], 1'b0);
        goto(48); chk("t3_high_e48", Slow_Clock[1], 1'b1);
        goto(49); chk("t3_fall_e49", Slow_Clock[1], 1'b0);

        // ch0 halts at edge 60, then a step pulse; ch3 gets a step while running.
        goto(50); Run[0] = 1'b0;
        goto(62); chk("t4_halt_e62", Halted[0], 1'b1); Step[0] = 1'b1;
        goto(63); Step[0] = 1'b0; chk("t4_halt_e63", Halted[0], !STEP_EN);
        goto(64); Step[3] = 1'b1;
        goto(65); Step[3] = 1'b0;
        goto(68); chk("t4_slow_e68", Slow_Clock[0], 1'b1);
        goto(69); chk("t4_slow_e69", Slow_Clock[0], !STEP_EN);
        goto(75); chk("t4_slow_e75", Slow_Clock[0], 1'b1); chk("t4_tick_e75", Rise_Tick[0], STEP_EN);
        goto(76); chk("t4_halt_e76", Halted[0], 1'b1);

        // div=0 to ch3; out-of-range write on the 3-channel bank.
        goto(80);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd0;
        b_valid = 1'b1; b_ch = 2'd3; b_div = 8'd0;
        #1 chk("t5_b_ready_pre", b_ready, 1'b1);
        goto(81); cfg_valid = 1'b0; b_valid = 1'b0;
        #1 chk("t5_ready_wait", cfg_ready, 1'b0); chk("t5_b_ready_post", b_ready, 1'b1);
        goto(83); chk("t5_slow_e83", Slow_Clock[3], 1'b0);
        goto(84); chk("t5_slow_e84", Slow_Clock[3], 1'b1); chk("t5_ready_e84", cfg_ready, 1'b1);
        goto(85); chk("t5_slow_e85", Slow_Clock[3], 1'b0); chk("t5_tick_e85", Rise_Tick[3], 1'b0);
        goto(86); chk("t5_slow_e86", Slow_Clock[3], 1'b1); chk("t5_tick_e86", Rise_Tick[3], 1'b1);
        goto(87); chk("t5_slow_e87", Slow_Clock[3], 1'b0);

        // Reset with ch2 pending and ch0 stepping (when enabled).
        goto(90); Step[0] = 1'b1;
        goto(91); Step[0] = 1'b0;
        goto(92); cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd7;
        goto(93); cfg_valid = 1'b0;
        #1 chk("t6_pending", cfg_ready, 1'b0);
        Reset = 1'b1;
        @(negedge Fast_Clock);
        chk("t6_slow", Slow_Clock, 4'hF);
        chk("t6_rise", Rise_Tick, 4'h0);
        chk("t6_halted", Halted, 4'h0);
        chk("t6_ready", cfg_ready, 1'b1);
        Run = 4'b0111; Reset = 1'b0;
        goto(1);  chk("t6_halt_run_low", Halted, 4'b1000); chk("t6_slow_e1", Slow_Clock, 4'hF);
        goto(6);  chk("t6_fall_e6", Slow_Clock, 4'b1000);
        goto(12); chk("t6_rise_e12", Slow_Clock, 4'hF); chk("t6_tick_e12", Rise_Tick, 4'b0111);

        @(negedge Fast_Clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
